fifo_push_arbiter: RTL and testbench

Round-robin arbiter that shares the push heads of a `fifo_sr` instance between several independent requesters. Each cycle it grants up to HEADS requesters, bounded by the free space the FIFO reports. It steers granted words onto the FIFO's `push`/`dinp` heads in arbitration order. A lock mechanism keeps multi-beat packets contiguous in the FIFO.

---
 rtl/fifo_arb_pkg.sv | 24 ++
 rtl/fifo_push_arbiter_if.sv | 33 +++
 rtl/fifo_push_arbiter_rr_pick.sv | 87 ++++++++
 rtl/fifo_push_arbiter.sv | 163 ++++++++++++++++
 tb/tb_fifo_push_arbiter.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and helpers for the fifo_push_arbiter slice.
//   arb_state_t : arbiter FSM state (open round-robin or locked to one owner)
//   RQ_IDX_W    : requester index width for the default configuration
//   CNT_W       : free-entry count width for the default configuration
//   wrap_inc    : modulo-n increment used to advance the round-robin pointer
package fifo_arb_pkg;

  typedef enum logic {
    ARB_OPEN   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  localparam int DEF_REQUESTERS = 4;
  localparam int DEF_DEPTH      = 16;

  localparam int RQ_IDX_W = $clog2(DEF_REQUESTERS);
  localparam int CNT_W    = $clog2(DEF_DEPTH) + 1;

  // Index after idx, wrapping at n back to 0.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fifo_push_arbiter_if.sv
// fifo_push_arbiter_if: requester handshake plus FIFO push-side bus.
//   req_valid/req_lock/req_data : requester words (master -> arbiter)
//   req_ready                   : per-requester grant (arbiter -> master)
//   push/dinp                   : FIFO push heads (arbiter -> FIFO)
//   src_num_avail               : FIFO free entries (FIFO -> arbiter)
// The master modport is the environment side (requesters and FIFO status);
// the slave modport is the arbiter.
interface fifo_push_arbiter_if #(
  parameter int WIDTH      = 32,
  parameter int REQUESTERS = 4,
  parameter int HEADS      = 2,
  parameter int DEPTH      = 16
);

  logic [REQUESTERS-1:0]            req_valid;
  logic [REQUESTERS-1:0]            req_lock;
  logic [REQUESTERS-1:0][WIDTH-1:0] req_data;
  logic [REQUESTERS-1:0]            req_ready;
  logic [HEADS-1:0]                 push;
  logic [HEADS-1:0][WIDTH-1:0]      dinp;
  logic [$clog2(DEPTH):0]           src_num_avail;

  modport master (
    output req_valid, req_lock, req_data, src_num_avail,
    input  req_ready, push, dinp
  );

  modport slave (
    input  req_valid, req_lock, req_data, src_num_avail,
    output req_ready, push, dinp
  );

endinterface

// File: rtl/fifo_push_arbiter_rr_pick.sv
// rr_pick: combinational round-robin multi-grant picker.
//   valid    in  candidate requesters
//   rr_ptr   in  highest-priority index
//   limit    in  maximum number of grants this cycle (<= HEADS)
//   grant    out granted mask in requester order
//   head_idx out requester index driving each head, in scan order
//   head_vld out head carries a grant
//   last_idx out last granted index in scan order
//   any_grant out at least one grant
// Rotates the valid vector so rr_ptr lands at bit 0, picks the first
// `limit` set bits, then rotates the picks back to requester indices.
module rr_pick #(
  parameter int REQUESTERS = 4,
  parameter int HEADS      = 2,
  parameter int IDX_W      = 2,
  parameter int CNT_W      = 5
) (
  input  logic [REQUESTERS-1:0]       valid,
  input  logic [IDX_W-1:0]            rr_ptr,
  input  logic [CNT_W-1:0]            limit,
  output logic [REQUESTERS-1:0]       grant,
  output logic [HEADS-1:0][IDX_W-1:0] head_idx,
  output logic [HEADS-1:0]            head_vld,
  output logic [IDX_W-1:0]            last_idx,
  output logic                        any_grant
);

  logic [REQUESTERS-1:0]       rot_valid;
  logic [REQUESTERS-1:0]       rot_grant;
  logic [HEADS-1:0][IDX_W-1:0] rot_head;
  int                          n_pick;

  // Rotated position off maps back to requester (base + off) mod REQUESTERS.
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                input int off);
    int s;
    s = int'(base) + off;
    if (s >= REQUESTERS) s = s - REQUESTERS;
    return IDX_W'(s);
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default before any branch so no
    // path leaves it unassigned and no latch is inferred.
    rot_valid = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      rot_valid[i] = valid[wrap_add(rr_ptr, i)];
    end
  end

  always_comb begin
    rot_grant = '0;
    rot_head  = '0;
    head_vld  = '0;
    n_pick    = 0;
    for (int i = 0; i < REQUESTERS; i++) begin
      if (rot_valid[i] && n_pick < int'(limit) && n_pick < HEADS) begin
        rot_grant[i] = 1'b1;
        for (int h = 0; h < HEADS; h++) begin
          if (h == n_pick) begin
            rot_head[h] = IDX_W'(i);
            head_vld[h] = 1'b1;
          end
        end
        n_pick = n_pick + 1;
      end
    end
  end

  always_comb begin
    grant    = '0;
    head_idx = '0;
    last_idx = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      if (rot_grant[i]) grant[wrap_add(rr_ptr, i)] = 1'b1;
    end
    for (int h = 0; h < HEADS; h++) begin
      if (head_vld[h]) begin
        head_idx[h] = wrap_add(rr_ptr, int'(rot_head[h]));
        last_idx    = wrap_add(rr_ptr, int'(rot_head[h]));
      end
    end
  end

  assign any_grant = |head_vld;

endmodule

// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter: round-robin sharing of a multi-head FIFO push port.
//   clk        in  clock
//   rst        in  synchronous active-high reset
//   bus        slave modport: requester handshake, FIFO push heads and
//              FIFO free-entry count
//   locked     out arbiter is holding a multi-beat packet for one owner
//   lock_owner out owner index while locked, 0 otherwise
// Up to min(HEADS, src_num_avail) requesters are granted per cycle; the
// k-th grant in scan order drives head k. A granted word with req_lock=1
// locks the arbiter to its requester until a beat with req_lock=0, so a
// packet lands contiguously in the FIFO.
module fifo_push_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int REQUESTERS = 4,
  parameter int HEADS      = 2,
  parameter int DEPTH      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  fifo_push_arbiter_if.slave            bus,
  output logic                          locked,
  output logic [$clog2(REQUESTERS)-1:0] lock_owner
);

  localparam int IDX_W   = $clog2(REQUESTERS);
  localparam int AVAIL_W = $clog2(DEPTH) + 1;

  if ((DEPTH < 1) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("fifo_push_arbiter: DEPTH must be a power of 2");
  end
  if (REQUESTERS < 2) begin : g_bad_requesters
    $error("fifo_push_arbiter: REQUESTERS must be at least 2");
  end
  if (HEADS < 1) begin : g_bad_heads
    $error("fifo_push_arbiter: HEADS must be at least 1");
  end

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;

  logic [AVAIL_W-1:0]          limit;
  logic [REQUESTERS-1:0]       owner_mask;
  logic [REQUESTERS-1:0]       pick_valid;
  logic [REQUESTERS-1:0]       pick_grant;
  logic [HEADS-1:0][IDX_W-1:0] head_idx;
  logic [HEADS-1:0]            head_vld;
  logic [IDX_W-1:0]            last_idx;
  logic                        any_grant;

  logic [HEADS-1:0]      keep_head;
  logic [REQUESTERS-1:0] drop_mask;
  logic                  lock_hit;
  logic [IDX_W-1:0]      lock_idx;

  // The FIFO count already includes last cycle's pushes, so it bounds
  // this cycle's grants directly.
  assign limit = (bus.src_num_avail >= AVAIL_W'(HEADS)) ? AVAIL_W'(HEADS)
                                                        : bus.src_num_avail;

  // While locked only the owner may be picked; with a single candidate
  // the picker puts it on head 0.
  assign owner_mask = {{(REQUESTERS-1){1'b0}}, 1'b1} << owner_q;
  assign pick_valid = (state_q == ARB_LOCKED) ? (bus.req_valid & owner_mask)
                                              : bus.req_valid;

  rr_pick #(
    .REQUESTERS (REQUESTERS),
    .HEADS      (HEADS),
    .IDX_W      (IDX_W),
    .CNT_W      (AVAIL_W)
  ) u_rr_pick (
    .valid     (pick_valid),
    .rr_ptr    (rr_ptr_q),
    .limit     (limit),
    .grant     (pick_grant),
    .head_idx  (head_idx),
    .head_vld  (head_vld),
    .last_idx  (last_idx),
    .any_grant (any_grant)
  );

  // The first locking grant in scan order claims the arbiter; any grant
  // after it is withdrawn so nothing interleaves with the packet.
  always_comb begin
    keep_head = head_vld;
    drop_mask = '0;
    lock_hit  = 1'b0;
    lock_idx  = '0;
    for (int h = 0; h < HEADS; h++) begin
      if (head_vld[h]) begin
        if (lock_hit) begin
          keep_head[h]          = 1'b0;
          drop_mask[head_idx[h]] = 1'b1;
        end else if (bus.req_lock[head_idx[h]]) begin
          lock_hit = 1'b1;
          lock_idx = head_idx[h];
        end
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    bus.push      = '0;
    bus.dinp      = '0;
    if (!rst) begin
      bus.req_ready = pick_grant & ~drop_mask;
      for (int h = 0; h < HEADS; h++) begin
        if (keep_head[h]) begin
          bus.push[h] = 1'b1;
          bus.dinp[h] = bus.req_data[head_idx[h]];
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    unique case (state_q)
      ARB_OPEN: begin
        if (lock_hit) begin
          state_d  = ARB_LOCKED;
          owner_d  = lock_idx;
          rr_ptr_d = IDX_W'(wrap_inc(int'(lock_idx), REQUESTERS));
        end else if (any_grant) begin
          rr_ptr_d = IDX_W'(wrap_inc(int'(last_idx), REQUESTERS));
        end
      end
      ARB_LOCKED: begin
        // A granted owner beat without req_lock closes the packet.
        if (keep_head[0] && !lock_hit) begin
          state_d  = ARB_OPEN;
          rr_ptr_d = IDX_W'(wrap_inc(int'(owner_q), REQUESTERS));
        end
      end
      default: state_d = ARB_OPEN;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order; reset is
    // synchronous, so it is simply the first branch of the clocked block.
    if (rst) begin
      state_q  <= ARB_OPEN;
      rr_ptr_q <= '0;
      owner_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
    end
  end

  assign locked     = (state_q == ARB_LOCKED);
  assign lock_owner = locked ? owner_q : '0;

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// tb_fifo_push_arbiter: directed bench for fifo_push_arbiter with
// REQUESTERS=4, HEADS=2, DEPTH=16. Inputs change on the falling edge and
// outputs are sampled 1 ns later, so each step checks the combinational
// grant for the cycle that the following rising edge commits.
module tb_fifo_push_arbiter;
  import fifo_arb_pkg::*;

  localparam int WIDTH      = 32;
  localparam int REQUESTERS = 4;
  localparam int HEADS      = 2;
  localparam int DEPTH      = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic                locked;
  logic [RQ_IDX_W-1:0] lock_owner;

  int n_assert = 0;
  int n_fail   = 0;

  fifo_push_arbiter_if #(
    .WIDTH      (WIDTH),
    .REQUESTERS (REQUESTERS),
    .HEADS      (HEADS),
    .DEPTH      (DEPTH)
  ) bus ();

  fifo_push_arbiter #(
    .WIDTH      (WIDTH),
    .REQUESTERS (REQUESTERS),
    .HEADS      (HEADS),
    .DEPTH      (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .locked     (locked),
    .lock_owner (lock_owner)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] D0 = 32'hC0DE_0000;
  localparam logic [31:0] D1 = 32'hC0DE_0001;
  localparam logic [31:0] D2 = 32'hC0DE_0002;
  localparam logic [31:0] D3 = 32'hC0DE_0003;
  localparam logic [31:0] B0 = 32'hBEA7_0000;
  localparam logic [31:0] B1 = 32'hBEA7_0001;
  localparam logic [31:0] B2 = 32'hBEA7_0002;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Requester 2 carries d2 so packet beats are distinguishable.
  task automatic drive(input logic r, input logic [3:0] valid,
                       input logic [3:0] lock, input logic [4:0] avail,
                       input logic [31:0] d2);
    @(negedge clk);
    rst               = r;
    bus.req_valid     = valid;
    bus.req_lock      = lock;
    bus.src_num_avail = avail;
    bus.req_data[0]   = D0;
    bus.req_data[1]   = D1;
    bus.req_data[2]   = d2;
    bus.req_data[3]   = D3;
    #1;
  endtask

  task automatic expect_push(input string tag, input logic [3:0] ready,
                             input logic [1:0] push, input logic [31:0] d0,
                             input logic [31:0] d1);
    check({tag, ".ready"}, 64'(bus.req_ready), 64'(ready));
    check({tag, ".push"},  64'(bus.push),      64'(push));
    check({tag, ".dinp0"}, 64'(bus.dinp[0]),   64'(d0));
    check({tag, ".dinp1"}, 64'(bus.dinp[1]),   64'(d1));
  endtask

  task automatic expect_lock(input string tag, input logic lk,
                             input logic [RQ_IDX_W-1:0] own);
    check({tag, ".locked"},     64'(locked),     64'(lk));
    check({tag, ".lock_owner"}, 64'(lock_owner), 64'(own));
  endtask

  initial begin
    rst = 1'b1;

    // Reset forces outputs low even with every requester valid.
    drive(1'b1, 4'b1111, 4'b0000, 5'd16, D2);
    expect_push("rst_hold", 4'b0000, 2'b00, 32'h0, 32'h0);

    // Full round-robin: {0,1}, {2,3}, {0,1}; avail=3 still allows 2 heads.
    drive(1'b0, 4'b1111, 4'b0000, 5'd16, D2);
    expect_lock("after_rst", 1'b0, 2'd0);
    expect_push("rr_c1", 4'b0011, 2'b11, D0, D1);
    drive(1'b0, 4'b1111, 4'b0000, 5'd16, D2);
    expect_push("rr_c2", 4'b1100, 2'b11, D2, D3);
    drive(1'b0, 4'b1111, 4'b0000, 5'd3, D2);
    expect_push("rr_c3", 4'b0011, 2'b11, D0, D1);

    // rr_ptr=2, requesters 1 and 3, one free slot: 3 wins on head 0.
    drive(1'b0, 4'b1010, 4'b0000, 5'd1, D2);
    expect_push("avail1", 4'b1000, 2'b01, D3, 32'h0);
    // Full FIFO: nothing granted, pointer unchanged (stays 0).
    drive(1'b0, 4'b1111, 4'b0000, 5'd0, D2);
    expect_push("avail0", 4'b0000, 2'b00, 32'h0, 32'h0);
    drive(1'b0, 4'b1111, 4'b0000, 5'd16, D2);
    expect_push("wrap_to0", 4'b0011, 2'b11, D0, D1);

    // rr_ptr=2: requester 2 opens a 3-beat packet, requester 3 suppressed.
    drive(1'b0, 4'b1111, 4'b0100, 5'd16, B0);
    expect_lock("pkt_b0_pre", 1'b0, 2'd0);
    expect_push("pkt_b0", 4'b0100, 2'b01, B0, 32'h0);
    drive(1'b0, 4'b1111, 4'b0100, 5'd16, B1);
    expect_lock("pkt_b1_lk", 1'b1, 2'd2);
    expect_push("pkt_b1", 4'b0100, 2'b01, B1, 32'h0);

    // Owner idles for 3 cycles: everyone else stays blocked.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'b1011, 4'b0000, 5'd16, B2);
      expect_lock("pkt_idle_lk", 1'b1, 2'd2);
      expect_push("pkt_idle", 4'b0000, 2'b00, 32'h0, 32'h0);
    end
    // Owner valid but FIFO full: still nothing.
    drive(1'b0, 4'b1111, 4'b0100, 5'd0, B2);
    expect_lock("pkt_full_lk", 1'b1, 2'd2);
    expect_push("pkt_full", 4'b0000, 2'b00, 32'h0, 32'h0);
    // Last beat closes the packet.
    drive(1'b0, 4'b1111, 4'b0000, 5'd16, B2);
    expect_lock("pkt_b2_lk", 1'b1, 2'd2);
    expect_push("pkt_b2", 4'b0100, 2'b01, B2, 32'h0);

    // Back to OPEN with rr_ptr=3: scan 3 then 0.
    drive(1'b0, 4'b1111, 4'b0000, 5'd16, D2);
    expect_lock("pkt_done", 1'b0, 2'd0);
    expect_push("rr_from3", 4'b1001, 2'b11, D3, D0);

    // rr_ptr=1: only 3 valid, moves pointer to 0.
    drive(1'b0, 4'b1000, 4'b0000, 5'd16, D2);
    expect_push("only3", 4'b1000, 2'b01, D3, 32'h0);

    // rr_ptr=0: requester 0 locks, requester 1 is suppressed.
    drive(1'b0, 4'b0011, 4'b0001, 5'd16, D2);
    expect_push("lock0", 4'b0001, 2'b01, D0, 32'h0);
    drive(1'b0, 4'b0011, 4'b0001, 5'd16, D2);
    expect_lock("lock0_lk", 1'b1, 2'd0);
    expect_push("lock0_b1", 4'b0001, 2'b01, D0, 32'h0);

    // Reset mid-packet: outputs forced low in the same cycle.
    drive(1'b1, 4'b1111, 4'b0001, 5'd16, D2);
    expect_push("rst_mid", 4'b0000, 2'b00, 32'h0, 32'h0);

    // Lock dropped, rr_ptr=0, normal round-robin resumes.
    drive(1'b0, 4'b1111, 4'b0000, 5'd16, D2);
    expect_lock("post_rst", 1'b0, 2'd0);
    expect_push("post_rst_c1", 4'b0011, 2'b11, D0, D1);
    drive(1'b0, 4'b1111, 4'b0000, 5'd16, D2);
    expect_push("post_rst_c2", 4'b1100, 2'b11, D2, D3);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
